// File: rtl/maquina_maluca_pkg.sv
// Shared state codes for the coffee-machine sequencing controller.
package maquina_maluca_pkg;

    typedef enum logic [3:0] {
        IDLE                = 4'd1,
        LIGAR_MAQUINA       = 4'd2,
        VERIFICAR_AGUA      = 4'd3,
        ENCHER_RESERVATORIO = 4'd4,
        MOER_CAFE           = 4'd5,
        COLOCAR_NO_FILTRO   = 4'd6,
        PASSAR_AGITADOR     = 4'd7,
        TAMPEAR             = 4'd8,
        REALIZAR_EXTRACAO   = 4'd9
    } state_e;

    localparam state_e RESET_STATE = IDLE;

endpackage

// File: rtl/maquina_maluca_fsm.sv
// Moore controller stepping through the brewing recipe after a start request;
// the reservoir is refilled once per brew, tracked by agua_ok.
module maquina_maluca_fsm
    import maquina_maluca_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   agua_ok_q, agua_ok_d;

    // NOTE: rst_n is active-high and synchronous here despite its name; it is only seen on a clock edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= RESET_STATE;
            agua_ok_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q   <= state_d;
            agua_ok_q <= agua_ok_d;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults first so no path leaves a signal unassigned (no latches).
        state_d   = state_q;
        agua_ok_d = agua_ok_q;
        case (state_q)
            IDLE:                if (start) state_d = LIGAR_MAQUINA;
            LIGAR_MAQUINA:       state_d = VERIFICAR_AGUA;
            VERIFICAR_AGUA:      state_d = agua_ok_q ? MOER_CAFE : ENCHER_RESERVATORIO;
            ENCHER_RESERVATORIO: begin
                agua_ok_d = 1'b1;
                state_d   = VERIFICAR_AGUA;
            end
            MOER_CAFE:           state_d = COLOCAR_NO_FILTRO;
            COLOCAR_NO_FILTRO:   state_d = PASSAR_AGITADOR;
            PASSAR_AGITADOR:     state_d = TAMPEAR;
            TAMPEAR:             state_d = REALIZAR_EXTRACAO;
            REALIZAR_EXTRACAO: begin
                agua_ok_d = 1'b0;
                state_d   = IDLE;
            end
            // Unreachable codes recover to a clean idle with the flag cleared.
            default: begin
                agua_ok_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_maquina_maluca_fsm.sv
// Self-checking bench: recipe-position model compared every cycle, plus directed literal sequences.
module tb_maquina_maluca_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    maquina_maluca_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a brew is one fixed list of codes walked one per edge; position -1 means idle.
    logic [3:0] recipe [10] = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
    int         pos = -1;
    logic [3:0] exp_state = 4'd1;
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            pos         = -1;
            model_valid = 1'b1;
        end else if (pos < 0) begin
            if (start) pos = 0;
        end else begin
            pos = pos + 1;
        end
        exp_state = (pos < 0) ? 4'd1 : recipe[pos];
        if (pos == 9) pos = -1;
    end

    always @(negedge clk) begin
        if (model_valid) check("model", state, exp_state);
    end

    task automatic step(input logic r, input logic s);
        @(negedge clk);
        rst_n = r;
        start = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string name, input logic r, input logic s, input logic [3:0] exp);
        step(r, s);
        check(name, state, exp);
    endtask

    logic [3:0] brew_lit [10] = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
    logic [3:0] toggle_lit [5] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd1};

    initial begin
        // Reset held two edges with arbitrary start, then released idle.
        step_chk("reset_hold0", 1'b1, 1'b1, 4'd1);
        step_chk("reset_hold1", 1'b1, 1'b0, 4'd1);
        for (int i = 0; i < 3; i++) step_chk("idle_after_reset", 1'b0, 1'b0, 4'd1);

        // Single-pulse start: full brew, then stays idle.
        step_chk("brew_start", 1'b0, 1'b1, brew_lit[0]);
        for (int i = 1; i < 10; i++) step_chk("brew_seq", 1'b0, 1'b0, brew_lit[i]);
        for (int i = 0; i < 2; i++) step_chk("brew_idle_hold", 1'b0, 1'b0, 4'd1);

        // Start held across two brews; water loop must reappear in the second.
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 10; i++) step_chk("continuous", 1'b0, 1'b1, brew_lit[i]);

        // Start toggled in states 5..9 has no effect.
        step_chk("toggle_start", 1'b0, 1'b1, 4'd2);
        for (int i = 1; i < 5; i++) step_chk("toggle_pre", 1'b0, 1'b0, brew_lit[i]);
        for (int i = 0; i < 5; i++) step_chk("toggle_mid", 1'b0, ((i % 2) == 0), toggle_lit[i]);
        step_chk("toggle_idle", 1'b0, 1'b0, 4'd1);

        // Reset while refilling, then while agitating with the flag set.
        step_chk("rst4_a", 1'b0, 1'b1, 4'd2);
        step_chk("rst4_b", 1'b0, 1'b0, 4'd3);
        step_chk("rst4_c", 1'b0, 1'b0, 4'd4);
        step_chk("rst4_reset", 1'b1, 1'b0, 4'd1);
        step_chk("rst7_start", 1'b0, 1'b1, brew_lit[0]);
        for (int i = 1; i < 7; i++) step_chk("rst7_seq", 1'b0, 1'b0, brew_lit[i]);
        step_chk("rst7_reset", 1'b1, 1'b1, 4'd1);
        step_chk("post_rst_start", 1'b0, 1'b1, 4'd2);
        step_chk("post_rst_chk", 1'b0, 1'b0, 4'd3);
        step_chk("post_rst_refill", 1'b0, 1'b0, 4'd4);
        for (int i = 3; i < 10; i++) step_chk("post_rst_seq", 1'b0, 1'b0, brew_lit[i]);

        // Reset and start together in idle: reset wins.
        step_chk("rst_vs_start", 1'b1, 1'b1, 4'd1);
        step_chk("rst_release", 1'b0, 1'b0, 4'd1);

        // Random traffic, checked every cycle by the model process.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0));

        step(1'b1, 1'b0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maquina_maluca_fsm.md
# maquina_maluca_fsm

Sequencing controller for the "máquina maluca" coffee-making demo. A single Moore state machine steps through a fixed brewing recipe after a start request. It exposes its current state as a 4-bit code for display and checking. It is a leaf block with no datapath and no handshakes beyond `start`.

## Interface
Parameters:
- None. State codes are fixed constants; see Structure.

Ports:
- `clk`  input  1  Single system clock; all logic is on the rising edge.
- `rst_n`  input  1  Reset. Synchronous and active-high: sampled on the rising edge of `clk`, and reset is in effect while it is 1.
- `start`  input  1  Brew request. Level-sampled; it matters only in IDLE.
- `state`  output  4  Current state code, driven directly from the state register.

## Operation
State codes (4-bit):
- IDLE = 1
- LIGAR_MAQUINA = 2
- VERIFICAR_AGUA = 3
- ENCHER_RESERVATORIO = 4
- MOER_CAFE = 5
- COLOCAR_NO_FILTRO = 6
- PASSAR_AGITADOR = 7
- TAMPEAR = 8
- REALIZAR_EXTRACAO = 9
- Codes 0 and 10–15 are never produced.

Internal flag `agua_ok` (1 bit, registered) records that the reservoir has been filled in the current brew cycle.

Transitions are evaluated every rising edge when not in reset:
- IDLE: if `start` = 1, go to LIGAR_MAQUINA; otherwise stay in IDLE.
- LIGAR_MAQUINA: go to VERIFICAR_AGUA.
- VERIFICAR_AGUA: if `agua_ok` = 0, go to ENCHER_RESERVATORIO; otherwise go to MOER_CAFE.
- ENCHER_RESERVATORIO: set `agua_ok` = 1 and go to VERIFICAR_AGUA.
- MOER_CAFE: go to COLOCAR_NO_FILTRO.
- COLOCAR_NO_FILTRO: go to PASSAR_AGITADOR.
- PASSAR_AGITADOR: go to TAMPEAR.
- TAMPEAR: go to REALIZAR_EXTRACAO.
- REALIZAR_EXTRACAO: clear `agua_ok` and go to IDLE.
- Any illegal code (0, 10–15): go to IDLE and clear `agua_ok`.

`start` is ignored outside IDLE. Holding `start` high through the end of a brew starts a new cycle in the edge after IDLE is reached.

## Timing
- Reset values: `state` = 1 (IDLE), `agua_ok` = 0. They take effect on the first rising edge with `rst_n` = 1.
- Reset has priority over all transitions, including mid-brew. It returns the machine to IDLE in one edge from any state.
- `state` is registered; there is no combinational path from `start` to `state`.
- Every non-IDLE state lasts exactly one clock.
- Full brew path from IDLE with `start` sampled high is 1→2→3→4→3→5→6→7→8→9→1. This is 10 edges from leaving IDLE to returning to it.
- Before the first reset the state is undefined; benches must reset first.

## Structure
- Shared package `maquina_maluca_pkg` holds:
  - the 4-bit state type and the nine named state constants;
  - the IDLE reset constant.
- Single module with no sub-modules. Use a state register plus a combinational next-state/next-flag block.
- `agua_ok` lives in the same module. It is not a port.

## Test plan
- Reset: hold `rst_n` = 1 for 2 edges with any `start` -> `state` = 1 on each check. Release with `start` = 0 for 3 edges -> `state` stays 1.
- Full brew: from IDLE, `start` = 1 for one edge then 0 -> per-edge `state` sequence 2,3,4,3,5,6,7,8,9,1. After that, `state` holds 1.
- Continuous start: `start` held at 1 across two brews -> after 9 the next value is 1, then 2. The water loop (3,4,3) repeats in the second brew, confirming `agua_ok` was cleared.
- Start ignored mid-brew: toggle `start` while in states 5–8 -> sequence unchanged, 5,6,7,8,9,1.
- Reset mid-operation: assert `rst_n` while `state` = 4, then later while `state` = 7 -> next edge `state` = 1. A subsequent brew again visits 4, proving the flag was reset.
- Reset versus start: `rst_n` = 1 and `start` = 1 on the same edge in IDLE -> `state` = 1, not 2.
